// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache with single outstanding fill
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic        busy,
  output logic [31:0] mc_pc,
  output logic        mc_miss,
  input  logic        mc_finish,
  input  logic [31:0] mc_ins
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TW = 32 - INDEX_BITS - 2;
  typedef enum logic {IDLE, MISS} state_t;
  state_t state_q;
  logic busy_q, ins_valid_q;
  logic [31:0] ins_out_q, miss_pc_q;
  logic [31:0] data_q [LINES];
  logic [TW-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [INDEX_BITS-1:0] idx, midx;
  logic hit;
  logic unused_ok;
  assign idx = fetch_pc[INDEX_BITS+1:2];
  assign midx = miss_pc_q[INDEX_BITS+1:2];
  assign hit = valid_q[idx] && tag_q[idx] == fetch_pc[31:INDEX_BITS+2];
  assign unused_ok = &{1'b0, fetch_pc[1:0]};
  assign mc_miss = state_q == MISS && !mc_finish && !rollback;
  assign mc_pc = state_q == MISS ? miss_pc_q : 32'd0;
  assign busy = busy_q;
  assign ins_valid = ins_valid_q;
  assign ins_out = ins_out_q;
  // Lookup/fill FSM; rdy low freezes everything, rollback drops any pending fill unwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      state_q <= IDLE;
      busy_q <= 1'b0;
      ins_valid_q <= 1'b0;
      ins_out_q <= '0;
      miss_pc_q <= '0;
    end else if (rdy) begin
      ins_valid_q <= 1'b0;
      if (rollback) begin
        state_q <= IDLE;
        busy_q <= 1'b0;
      end else if (state_q == IDLE) begin
        if (fetch_req && hit) begin
          ins_valid_q <= 1'b1;
          ins_out_q <= data_q[idx];
        end else if (fetch_req) begin
          miss_pc_q <= fetch_pc;
          state_q <= MISS;
          busy_q <= 1'b1;
        end
      end else if (mc_finish) begin
        data_q[midx] <= mc_ins;
        tag_q[midx] <= miss_pc_q[31:INDEX_BITS+2];
        valid_q[midx] <= 1'b1;
        ins_valid_q <= 1'b1;
        ins_out_q <= mc_ins;
        busy_q <= 1'b0;
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed checks of icache hit/miss, eviction, rollback, rdy stall and reset
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1, rdy = 1'b1, rollback = 1'b0, fetch_req = 1'b0, mc_finish = 1'b0;
  logic [31:0] fetch_pc = '0, mc_ins = '0;
  logic ins_valid, busy, mc_miss;
  logic [31:0] ins_out, mc_pc;
  int checks = 0, failures = 0;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .ins_valid(ins_valid), .ins_out(ins_out), .busy(busy),
    .mc_pc(mc_pc), .mc_miss(mc_miss), .mc_finish(mc_finish), .mc_ins(mc_ins)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_req = 1'b1;
    fetch_pc = pc;
    cyc();
    fetch_req = 1'b0;
  endtask

  task automatic finish(input logic [31:0] w);
    mc_finish = 1'b1;
    mc_ins = w;
    cyc();
    mc_finish = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", ins_valid, 0);
    chk("rst_out", ins_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miss", mc_miss, 0);
    chk("rst_pc", mc_pc, 0);
    // cold miss then hit
    fetch_req = 1'b1;
    fetch_pc = 32'h4;
    #1 chk("c1_miss", mc_miss, 0);
    cyc();
    fetch_req = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      #1 chk($sformatf("c%0d_miss", i), mc_miss, 1);
      chk($sformatf("c%0d_busy", i), busy, 1);
      chk($sformatf("c%0d_iv", i), ins_valid, 0);
      cyc();
    end
    mc_finish = 1'b1;
    mc_ins = 32'h00A00093;
    #1 chk("c5_miss", mc_miss, 0);
    chk("c5_pc", mc_pc, 32'h4);
    cyc();
    mc_finish = 1'b0;
    chk("fill_iv", ins_valid, 1);
    chk("fill_out", ins_out, 32'h00A00093);
    chk("fill_busy", busy, 0);
    cyc();
    chk("pulse_end", ins_valid, 0);
    fetch_req = 1'b1;
    #1 chk("hit_nomiss", mc_miss, 0);
    cyc();
    fetch_req = 1'b0;
    chk("hit_iv", ins_valid, 1);
    chk("hit_out", ins_out, 32'h00A00093);
    chk("hit_busy", busy, 0);
    // conflict eviction
    fetch(32'h104);
    cyc();
    finish(32'h11111111);
    chk("ev_fill_out", ins_out, 32'h11111111);
    fetch(32'h4);
    chk("ev_iv", ins_valid, 0);
    chk("ev_busy", busy, 1);
    #1 chk("ev_miss", mc_miss, 1);
    chk("ev_pc", mc_pc, 32'h4);
    finish(32'h00A00093);
    chk("ev_refill", ins_valid, 1);
    // rollback coincident with mc_finish
    fetch(32'h8);
    cyc();
    rollback = 1'b1;
    mc_finish = 1'b1;
    mc_ins = 32'hDEADBEEF;
    #1 chk("rb_miss", mc_miss, 0);
    cyc();
    rollback = 1'b0;
    mc_finish = 1'b0;
    chk("rb_iv", ins_valid, 0);
    chk("rb_busy", busy, 0);
    #1 chk("rb_pc", mc_pc, 0);
    fetch(32'h4);
    chk("rb_keep_iv", ins_valid, 1);
    chk("rb_keep_out", ins_out, 32'h00A00093);
    fetch(32'h8);
    chk("rb_re_iv", ins_valid, 0);
    chk("rb_re_busy", busy, 1);
    #1 chk("rb_re_pc", mc_pc, 32'h8);
    finish(32'h22222222);
    chk("rb_fill_out", ins_out, 32'h22222222);
    // rdy low mid-miss
    fetch(32'hC);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_busy", busy, 1);
      chk("stall_iv", ins_valid, 0);
      chk("stall_pc", mc_pc, 32'hC);
      chk("stall_miss", mc_miss, 1);
    end
    rdy = 1'b1;
    finish(32'h33333333);
    chk("stall_fill_iv", ins_valid, 1);
    chk("stall_fill_out", ins_out, 32'h33333333);
    // reset mid-fill
    fetch(32'h14);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_busy", busy, 0);
    #1 chk("mr_miss", mc_miss, 0);
    chk("mr_pc", mc_pc, 0);
    finish(32'hFFFFFFFF);
    chk("mr_iv", ins_valid, 0);
    chk("mr_out", ins_out, 0);
    fetch(32'h14);
    chk("mr_re_iv", ins_valid, 0);
    chk("mr_re_busy", busy, 1);
    finish(32'h44444444);
    chk("mr_fill_out", ins_out, 32'h44444444);
    // request during MISS is ignored
    fetch_req = 1'b1;
    fetch_pc = 32'h10;
    cyc();
    fetch_pc = 32'h20;
    cyc();
    #1 chk("dm_pc", mc_pc, 32'h10);
    chk("dm_iv", ins_valid, 0);
    finish(32'h55555555);
    fetch_req = 1'b0;
    chk("dm_iv1", ins_valid, 1);
    chk("dm_out", ins_out, 32'h55555555);
    cyc();
    chk("dm_iv2", ins_valid, 0);
    chk("dm_busy", busy, 0);
    // mc_finish in IDLE has no effect
    finish(32'h66666666);
    chk("idle_fin_iv", ins_valid, 0);
    chk("idle_fin_out", ins_out, 32'h55555555);
    fetch(32'h10);
    chk("idle_fin_hit", ins_out, 32'h55555555);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 6, meaning log2 of the line count (64 one-word lines).
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-005 The block SHALL have port rollback  input  1  pipeline flush; abandons any pending fill.
REQ-006 The block SHALL have port fetch_req  input  1  fetch unit requests the instruction at fetch_pc.
REQ-007 The block SHALL have port fetch_pc  input  32  byte address of the instruction; bits [1:0] are always 0.
REQ-008 The block SHALL have port ins_valid  output  1  registered one-cycle pulse: ins_out is valid.
REQ-009 The block SHALL have port ins_out  output  32  returned instruction word.
REQ-010 The block SHALL have port busy  output  1  registered; high while a fill is outstanding.
REQ-011 The block SHALL have port mc_pc  output  32  fill address to the memory controller.
REQ-012 The block SHALL have port mc_miss  output  1  fill request to the memory controller (combinational, see REQ-019).
REQ-013 The block SHALL have port mc_finish  input  1  memory controller one-cycle pulse: mc_ins is valid.
REQ-014 The block SHALL have port mc_ins  input  32  fetched word, little-endian assembled.

Function
REQ-015 Storage SHALL be direct-mapped, one 32-bit word per line.
- Index = pc[INDEX_BITS+1:2].
- Tag = pc[31:INDEX_BITS+2].
- One valid bit per line.
REQ-016 The block SHALL have two states: IDLE and MISS.
REQ-017 In IDLE, when fetch_req is high and the line hits (valid and tag equal):
- Next edge: ins_valid=1 and ins_out=stored word.
- Latency is 1 cycle.
- State stays IDLE.
REQ-018 In IDLE, when fetch_req is high and the line misses:
- Next edge: miss_pc<=fetch_pc, state<=MISS, busy<=1, ins_valid=0.
REQ-019 mc_miss SHALL equal (state==MISS) && !mc_finish && !rollback.
- This prevents the controller, which is idle during the finish cycle, from re-sampling a stale request.
REQ-020 mc_pc SHALL equal miss_pc in MISS and 0 in IDLE.
REQ-021 In MISS, fetch_req and fetch_pc SHALL be ignored; the fetch unit re-presents its request after ins_valid or rollback.
REQ-022 In MISS, when mc_finish is high, at that edge the block SHALL:
- Write mc_ins into line index(miss_pc).
- Set the line's tag and valid bit.
- Drive ins_valid=1 and ins_out=mc_ins (bypass).
- Set busy=0 and state=IDLE.
- Miss latency is therefore the memory-controller latency plus 0 extra cycles.
REQ-023 ins_valid SHALL be low in every cycle not covered by REQ-017 or REQ-022; ins_out SHALL hold its last value.
REQ-024 When rollback is high (with rdy high), next edge:
- State=IDLE, busy=0, ins_valid=0.
- No line is written, even if mc_finish is high in the same cycle.
- Valid bits are retained.
- A fetch_req in the same cycle is dropped.
REQ-025 When rdy is low, no register or array SHALL change; mc_miss still follows REQ-019.
REQ-026 A fill SHALL replace a valid line at the same index without conditions; no coherence with stores is provided.
REQ-027 Precedence SHALL be rst > !rdy > rollback > normal operation.

Reset
REQ-028 On rst high at posedge, the block SHALL set:
- All valid bits=0, state=IDLE, busy=0, ins_valid=0, ins_out=0, miss_pc=0.
- Consequently mc_miss=0 and mc_pc=0.
REQ-029 Reset asserted mid-fill SHALL abandon the fill with no line written; a later mc_finish in IDLE SHALL be ignored.
REQ-030 mc_finish arriving in IDLE SHALL never write the array or pulse ins_valid.

Verification
REQ-031 The bench SHALL cover a cold miss then a hit:
- Stimulus: after reset, fetch_req with pc=0x00000004; mc_finish on cycle 5 with mc_ins=0x00A00093; later re-request pc=0x00000004.
- Response: mc_miss high cycles 2-4 and low on 5 with mc_pc=0x4; ins_valid=1 and ins_out=0x00A00093 after the cycle-5 edge; the re-request returns ins_valid one cycle later with no mc_miss.
REQ-032 The bench SHALL cover a conflict eviction:
- Stimulus: fill pc=0x4, then fill pc=0x104 (same index, tag 1), then request pc=0x4.
- Response: the final request misses, mc_miss is asserted with mc_pc=0x4.
REQ-033 The bench SHALL cover rollback coincident with mc_finish:
- Stimulus: rollback and mc_finish in the same cycle for pc=0x8; then request pc=0x8.
- Response: ins_valid stays 0; the second request misses.
REQ-034 The bench SHALL cover rdy low mid-miss:
- Stimulus: rdy=0 for 3 cycles while in MISS.
- Response: state, busy and miss_pc are unchanged; the fill completes normally after rdy=1.
REQ-035 The bench SHALL cover reset mid-fill:
- Stimulus: rst during MISS, then mc_finish pulse with mc_ins=0xFFFFFFFF.
- Response: no ins_valid; a subsequent request to the same pc misses.
REQ-036 The bench SHALL cover a request during MISS:
- Stimulus: fetch_req with pc=0x20 while filling 0x10.
- Response: mc_pc stays 0x10; only one ins_valid, carrying the 0x10 word.
